// File: rtl/hazard_forward_ctrl_if.sv
// ID-stage request and stall/forward response bundle for hazard_forward_ctrl.
// The pipeline control side drives master; the hazard unit uses slave.
interface hazard_forward_ctrl_if #(
    parameter int NUM_SRC = 2,
    parameter int ADDR_W  = 5,
    parameter int SEL_W   = 3
);
    logic                       id_valid;
    logic [NUM_SRC*ADDR_W-1:0]  id_src;
    logic [NUM_SRC-1:0]         id_src_used;
    logic                       id_reg_write;
    logic [ADDR_W-1:0]          id_dst;
    logic                       id_is_load;
    logic                       flush;
    logic                       hold;
    logic                       stall;
    logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
    logic [15:0]                stall_count;

    modport master (
        output id_valid, id_src, id_src_used, id_reg_write, id_dst, id_is_load, flush, hold,
        input  stall, fwd_sel, stall_count
    );

    modport slave (
        input  id_valid, id_src, id_src_used, id_reg_write, id_dst, id_is_load, flush, hold,
        output stall, fwd_sel, stall_count
    );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Load-use stall detection and EX operand forward-select generation.
// Tracks in-flight destinations per stage; youngest matching producer wins.
module hazard_forward_ctrl #(
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int ADDR_W     = 5,
    parameter int LOAD_READY = 2,
    parameter int SEL_W      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_forward_ctrl_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [ADDR_W-1:0] dst;
        logic              is_load;
    } entry_t;

    entry_t [DEPTH-1:0]             pipe_q, pipe_d;
    logic [NUM_SRC-1:0][SEL_W-1:0]  fwd_q, fwd_d;
    logic [15:0]                    stall_cnt_q, stall_cnt_d;

    logic [NUM_SRC-1:0][ADDR_W-1:0] src;
    logic [NUM_SRC-1:0]             found;
    logic [NUM_SRC-1:0]             op_stall;
    logic [NUM_SRC-1:0][SEL_W-1:0]  op_sel;
    logic                           hazard;
    entry_t                         id_entry;

    assign src = bus.id_src;

    // Per operand: first (youngest) match decides; it sits in stage j+1 after the edge.
    // A match in the last stage retires now and the write-first regfile supplies it.
    always_comb begin
        found    = '0;
        op_stall = '0;
        op_sel   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (!found[i] && bus.id_valid && bus.id_src_used[i] &&
                    pipe_q[j].valid && pipe_q[j].reg_write &&
                    (pipe_q[j].dst != '0) && (pipe_q[j].dst == src[i])) begin
                    found[i] = 1'b1;
                    if (j < DEPTH-1) begin
                        if (pipe_q[j].is_load && (j + 1) < LOAD_READY)
                            op_stall[i] = 1'b1;
                        else
                            op_sel[i] = SEL_W'(j + 1);
                    end
                end
            end
        end
    end

    assign hazard    = |op_stall;
    assign bus.stall = hazard & ~bus.flush & ~bus.hold;

    always_comb begin
        id_entry.valid     = bus.id_valid;
        id_entry.reg_write = bus.id_reg_write;
        id_entry.dst       = bus.id_dst;
        id_entry.is_load   = bus.id_is_load;
    end

    always_comb begin
        pipe_d      = pipe_q;
        fwd_d       = fwd_q;
        stall_cnt_d = stall_cnt_q;
        if (bus.flush || !bus.hold) begin
            for (int k = 1; k < DEPTH; k++)
                pipe_d[k] = pipe_q[k-1];
            if (bus.flush) begin
                pipe_d[0] = '0;
                fwd_d     = '0;
            end else if (hazard) begin
                pipe_d[0] = '0;
                fwd_d     = '0;
                if (stall_cnt_q != 16'hFFFF)
                    stall_cnt_d = stall_cnt_q + 16'd1;
            end else begin
                pipe_d[0] = id_entry;
                fwd_d     = op_sel;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q      <= '0;
            fwd_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            pipe_q      <= pipe_d;
            fwd_q       <= fwd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.fwd_sel     = fwd_q;
    assign bus.stall_count = stall_cnt_q;
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: default instance plus a DEPTH=4/LOAD_READY=3 instance,
// directed scenarios and random traffic against an instruction-history reference model.
module tb_hazard_forward_ctrl;
    localparam int NS = 2;
    localparam int AW = 5;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_forward_ctrl_if #(.NUM_SRC(NS), .ADDR_W(AW), .SEL_W(SW)) ifa ();
    hazard_forward_ctrl_if #(.NUM_SRC(NS), .ADDR_W(AW), .SEL_W(SW)) ifb ();

    hazard_forward_ctrl #(.NUM_SRC(NS), .DEPTH(3), .ADDR_W(AW), .LOAD_READY(2), .SEL_W(SW))
        dut (.clk(clk), .rst(rst), .bus(ifa.slave));
    hazard_forward_ctrl #(.NUM_SRC(NS), .DEPTH(4), .ADDR_W(AW), .LOAD_READY(3), .SEL_W(SW))
        dutb (.clk(clk), .rst(rst), .bus(ifb.slave));

    typedef struct { bit v; int s0; int s1; bit [1:0] used; bit rw; int dst; bit ld; bit fl; bit hd; } stim_t;
    typedef struct { bit v; bit rw; bit ld; int dst; } ins_t;

    // Reference: hist[u][k] is the instruction issued k+1 cycles ago (k=0 is in EX).
    ins_t hist [2][6];
    int   mfwd [2][NS];
    int   mcnt [2];
    bit   p_stall [2];
    int   p_sel [2][NS];
    logic last_stall;
    int   npass = 0;
    int   ntot  = 0;

    function automatic stim_t mk(bit v, int s0, int s1, bit [1:0] used, bit rw, int dst, bit ld, bit fl, bit hd);
        stim_t s;
        s.v = v; s.s0 = s0; s.s1 = s1; s.used = used; s.rw = rw; s.dst = dst; s.ld = ld; s.fl = fl; s.hd = hd;
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(1'b0, 0, 0, 2'b00, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.v    = ($urandom_range(9) != 0);
        s.s0   = int'($urandom_range(3));
        s.s1   = int'($urandom_range(3));
        s.used = {($urandom_range(3) != 0), ($urandom_range(3) != 0)};
        s.rw   = ($urandom_range(3) != 0);
        s.dst  = int'($urandom_range(3));
        s.ld   = ($urandom_range(2) == 0);
        s.fl   = ($urandom_range(11) == 0);
        s.hd   = ($urandom_range(11) == 0);
        return s;
    endfunction

    function automatic logic stall_of(int u);
        return (u != 0) ? ifb.stall : ifa.stall;
    endfunction

    function automatic logic [SW-1:0] sel_of(int u, int i);
        return (u != 0) ? ifb.fwd_sel[i*SW +: SW] : ifa.fwd_sel[i*SW +: SW];
    endfunction

    function automatic logic [15:0] cnt_of(int u);
        return (u != 0) ? ifb.stall_count : ifa.stall_count;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic drive(int u, stim_t st);
        if (u != 0) begin
            ifb.id_valid = st.v; ifb.id_src = {AW'(st.s1), AW'(st.s0)}; ifb.id_src_used = st.used;
            ifb.id_reg_write = st.rw; ifb.id_dst = AW'(st.dst); ifb.id_is_load = st.ld;
            ifb.flush = st.fl; ifb.hold = st.hd;
        end else begin
            ifa.id_valid = st.v; ifa.id_src = {AW'(st.s1), AW'(st.s0)}; ifa.id_src_used = st.used;
            ifa.id_reg_write = st.rw; ifa.id_dst = AW'(st.dst); ifa.id_is_load = st.ld;
            ifa.flush = st.fl; ifa.hold = st.hd;
        end
    endtask

    task automatic mreset();
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 6; k++) hist[u][k] = '{1'b0, 1'b0, 1'b0, 0};
            for (int i = 0; i < NS; i++) mfwd[u][i] = 0;
            mcnt[u] = 0;
        end
    endtask

    // Walk the history from youngest to oldest; the first writer of the source decides.
    task automatic predict(int u, stim_t st);
        int d = (u != 0) ? 4 : 3;
        int r = (u != 0) ? 3 : 2;
        p_stall[u] = 1'b0;
        for (int i = 0; i < NS; i++) begin
            int s = (i != 0) ? st.s1 : st.s0;
            p_sel[u][i] = 0;
            if (st.v && st.used[i] && s != 0) begin
                for (int age = 0; age < d; age++) begin
                    if (hist[u][age].v && hist[u][age].rw && hist[u][age].dst == s) begin
                        if (age + 1 < d) begin
                            if (hist[u][age].ld && age + 1 < r) p_stall[u] = 1'b1;
                            else p_sel[u][i] = age + 1;
                        end
                        break;
                    end
                end
            end
        end
    endtask

    task automatic commit(int u, stim_t st);
        int d = (u != 0) ? 4 : 3;
        if (st.fl || !st.hd) begin
            for (int k = d - 1; k > 0; k--) hist[u][k] = hist[u][k-1];
            if (st.fl || p_stall[u]) begin
                hist[u][0] = '{1'b0, 1'b0, 1'b0, 0};
                for (int i = 0; i < NS; i++) mfwd[u][i] = 0;
                if (!st.fl && mcnt[u] < 65535) mcnt[u]++;
            end else begin
                hist[u][0] = '{st.v, st.rw, st.ld, st.dst};
                for (int i = 0; i < NS; i++) mfwd[u][i] = p_sel[u][i];
            end
        end
    endtask

    // One cycle: unit u gets st, the other instance idles. Called and returns at negedge.
    task automatic step(int u, stim_t st, string tag);
        stim_t cur [2];
        cur[0] = idle(); cur[1] = idle(); cur[u] = st;
        drive(0, cur[0]); drive(1, cur[1]);
        #1;
        predict(0, cur[0]); predict(1, cur[1]);
        last_stall = stall_of(u);
        chk({tag, ".stall"}, 32'(last_stall), 32'(p_stall[u] && !st.fl && !st.hd));
        @(posedge clk); #1;
        commit(0, cur[0]); commit(1, cur[1]);
        for (int i = 0; i < NS; i++) chk($sformatf("%s.fwd%0d", tag, i), 32'(sel_of(u, i)), 32'(mfwd[u][i]));
        chk({tag, ".cnt"}, 32'(cnt_of(u)), 32'(mcnt[u]));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, idle()); drive(1, idle());
        mreset();
        #2;
        chk("rst.stall", 32'(ifa.stall), 32'd0);
        chk("rst.fwd", 32'(ifa.fwd_sel), 32'd0);
        chk("rst.cnt", 32'(ifa.stall_count), 32'd0);
        chk("rst.cntb", 32'(ifb.stall_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ALU -> dependent next instruction forwards from MEM
        step(0, mk(1, 0, 0, 2'b00, 1, 5, 0, 0, 0), "alu1.w");
        step(0, mk(1, 5, 0, 2'b01, 0, 0, 0, 0, 0), "alu1.r");
        chk("alu1.nostall", 32'(last_stall), 32'd0);
        chk("alu1.fwd_mem", 32'(sel_of(0, 0)), 32'd1);

        // One gap -> WB, both operands; then youngest of two writers wins
        step(0, mk(1, 0, 0, 2'b00, 1, 5, 0, 0, 0), "alu2.w");
        step(0, mk(1, 0, 0, 2'b00, 1, 6, 0, 0, 0), "alu2.x");
        step(0, mk(1, 5, 5, 2'b11, 0, 0, 0, 0, 0), "alu2.r");
        chk("alu2.fwd_wb0", 32'(sel_of(0, 0)), 32'd2);
        chk("alu2.fwd_wb1", 32'(sel_of(0, 1)), 32'd2);
        step(0, mk(1, 0, 0, 2'b00, 1, 5, 0, 0, 0), "alu3.wa");
        step(0, mk(1, 0, 0, 2'b00, 1, 5, 0, 0, 0), "alu3.wb");
        step(0, mk(1, 5, 0, 2'b01, 0, 0, 0, 0, 0), "alu3.r");
        chk("alu3.youngest", 32'(sel_of(0, 0)), 32'd1);

        // Load-use: one bubble, then WB forward
        step(0, mk(1, 0, 0, 2'b00, 1, 8, 1, 0, 0), "ld.w");
        step(0, mk(1, 8, 0, 2'b01, 0, 0, 0, 0, 0), "ld.r1");
        chk("ld.stall1", 32'(last_stall), 32'd1);
        chk("ld.cnt1", 32'(cnt_of(0)), 32'd1);
        step(0, mk(1, 8, 0, 2'b01, 0, 0, 0, 0, 0), "ld.r2");
        chk("ld.stall2", 32'(last_stall), 32'd0);
        chk("ld.fwd_wb", 32'(sel_of(0, 0)), 32'd2);
        chk("ld.cnt2", 32'(cnt_of(0)), 32'd1);

        // $0 never matches; unused operand never matches
        step(0, mk(1, 0, 0, 2'b00, 1, 0, 1, 0, 0), "r0.w");
        step(0, mk(1, 0, 0, 2'b11, 0, 0, 0, 0, 0), "r0.r");
        chk("r0.nostall", 32'(last_stall), 32'd0);
        chk("r0.fwd", 32'(sel_of(0, 0)), 32'd0);
        step(0, mk(1, 0, 0, 2'b00, 1, 9, 1, 0, 0), "nu.w");
        step(0, mk(1, 9, 9, 2'b00, 0, 0, 0, 0, 0), "nu.r");
        chk("nu.nostall", 32'(last_stall), 32'd0);
        chk("nu.fwd", 32'(sel_of(0, 0)), 32'd0);

        // hold masks the stall and freezes everything; the stall returns on release
        step(0, mk(1, 0, 0, 2'b00, 1, 8, 1, 0, 0), "hd.w");
        step(0, mk(1, 8, 0, 2'b01, 0, 0, 0, 0, 1), "hd.h");
        chk("hd.nostall", 32'(last_stall), 32'd0);
        chk("hd.cnt_frozen", 32'(cnt_of(0)), 32'd1);
        step(0, mk(1, 8, 0, 2'b01, 0, 0, 0, 0, 0), "hd.r1");
        chk("hd.stall_back", 32'(last_stall), 32'd1);
        chk("hd.cnt", 32'(cnt_of(0)), 32'd2);
        step(0, mk(1, 8, 0, 2'b01, 0, 0, 0, 0, 0), "hd.r2");
        chk("hd.fwd_wb", 32'(sel_of(0, 0)), 32'd2);

        // flush masks the stall and drops the ID instruction (its $9 write never tracked)
        step(0, mk(1, 0, 0, 2'b00, 1, 8, 1, 0, 0), "fl.w");
        step(0, mk(1, 8, 0, 2'b01, 1, 9, 0, 1, 0), "fl.f");
        chk("fl.nostall", 32'(last_stall), 32'd0);
        chk("fl.cnt", 32'(cnt_of(0)), 32'd2);
        step(0, mk(1, 9, 0, 2'b01, 0, 0, 0, 0, 0), "fl.r");
        chk("fl.p0_bubble", 32'(sel_of(0, 0)), 32'd0);

        for (int n = 0; n < 200; n++) step(0, rnd(), $sformatf("rndA%0d", n));

        // Deeper instance: two load-use bubbles, then stage-3 forward
        step(1, mk(1, 0, 0, 2'b00, 1, 3, 1, 0, 0), "b.w");
        step(1, mk(1, 3, 0, 2'b01, 0, 0, 0, 0, 0), "b.r1");
        chk("b.stall1", 32'(last_stall), 32'd1);
        step(1, mk(1, 3, 0, 2'b01, 0, 0, 0, 0, 0), "b.r2");
        chk("b.stall2", 32'(last_stall), 32'd1);
        step(1, mk(1, 3, 0, 2'b01, 0, 0, 0, 0, 0), "b.r3");
        chk("b.stall3", 32'(last_stall), 32'd0);
        chk("b.fwd3", 32'(sel_of(1, 0)), 32'd3);
        chk("b.cnt", 32'(cnt_of(1)), 32'd2);

        // Saturation from a preloaded counter
        force dutb.stall_cnt_q = 16'hFFFF;
        #1;
        release dutb.stall_cnt_q;
        mcnt[1] = 65535;
        step(1, mk(1, 0, 0, 2'b00, 1, 3, 1, 0, 0), "sat.w");
        step(1, mk(1, 3, 0, 2'b01, 0, 0, 0, 0, 0), "sat.r");
        chk("sat.stall", 32'(last_stall), 32'd1);
        chk("sat.hold_ffff", 32'(cnt_of(1)), 32'hFFFF);

        // Reset mid-stall clears state without a clock edge
        drive(0, idle());
        drive(1, mk(1, 3, 0, 2'b01, 0, 0, 0, 0, 0));
        #1;
        chk("mrst.pre_stall", 32'(ifb.stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("mrst.stall", 32'(ifb.stall), 32'd0);
        chk("mrst.cntb", 32'(ifb.stall_count), 32'd0);
        chk("mrst.cnta", 32'(ifa.stall_count), 32'd0);
        chk("mrst.fwdb", 32'(ifb.fwd_sel), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mreset();
        step(1, mk(1, 3, 0, 2'b01, 0, 0, 0, 0, 0), "post.r");
        chk("post.nostall", 32'(last_stall), 32'd0);
        chk("post.fwd", 32'(sel_of(1, 0)), 32'd0);

        for (int n = 0; n < 200; n++) step(1, rnd(), $sformatf("rndB%0d", n));

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
